// File: rtl/uart_receiver_pkg.sv
// Shared UART receive definitions: LCR bit positions, receiver state encodings,
// receive FIFO geometry and the bit-level helper functions used by the receiver.
package uart_receiver_pkg;

  localparam int RF_DEPTH = 16;
  localparam int RF_WIDTH = 11;
  localparam int RF_CNT_W = 5;

  localparam int LC_BITS = 0;
  localparam int LC_PE   = 3;
  localparam int LC_EP   = 4;
  localparam int LC_SP   = 5;

  typedef enum logic [2:0] {
    r_idle       = 3'd0,
    r_rec_start  = 3'd1,
    r_rec_bit    = 3'd2,
    r_rec_parity = 3'd3,
    r_rec_stop   = 3'd4,
    r_push       = 3'd5,
    r_wait_high  = 3'd6
  } rstate_t;

  function automatic logic expected_parity(input logic [7:0] data, input logic ep, input logic sp);
    logic par;
    case ({ep, sp})
      2'b00:   par = ~^data;
      2'b10:   par = ^data;
      2'b01:   par = 1'b1;
      2'b11:   par = 1'b0;
      default: par = 1'b0;
    endcase
    return par;
  endfunction

  // LSB-first reception: new bit lands at the word MSB, older bits move down.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b, input logic [1:0] wl);
    logic [7:0] nxt;
    nxt = cur >> 1;
    nxt[{1'b1, wl}] = b;
    return nxt;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_rfifo.sv
// Receive FIFO: synchronous storage with occupancy count, sticky overrun flag
// and a per-entry error marker summarised into a single error bit.
module uart_rfifo
  import uart_receiver_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic                clr_overrun,
  input  logic [RF_WIDTH-1:0] data_in,
  output logic [RF_WIDTH-1:0] data_out,
  output logic [PTR_W:0]      count,
  output logic                overrun,
  output logic                error_bit
);

  logic [RF_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic [DEPTH-1:0]    err_r;
  logic                overrun_r;
  logic                full_s;
  logic                empty_s;
  logic                do_pop_s;
  logic                do_push_s;

  assign full_s    = (count_r == (PTR_W+1)'(DEPTH));
  assign empty_s   = (count_r == '0);
  assign do_pop_s  = pop && !empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push_s = push && (!full_s || do_pop_s);

  // Storage, pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      err_r     <= '0;
      overrun_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (flush) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      err_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (do_pop_s) begin
        rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
        err_r[rd_ptr_r] <= 1'b0;
      end
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= data_in;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        err_r[wr_ptr_r] <= |data_in[2:0];
      end
      count_r <= count_r + (PTR_W+1)'(do_push_s) - (PTR_W+1)'(do_pop_s);
      if (push && full_s && !do_pop_s) overrun_r <= 1'b1;
      else if (clr_overrun)            overrun_r <= 1'b0;
    end
  end

  assign data_out  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign overrun   = overrun_r;
  assign error_bit = |err_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchronises srx_pad_i, frames start/data/parity/stop bits
// and pushes each frame into uart_rfifo. Optional UART_RX_MAJORITY_VOTE_EN votes each bit.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = RF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          lcr,
  input  logic                enable,
  input  logic                srx_pad_i,
  input  logic                rf_pop,
  input  logic                rx_reset,
  input  logic                lsr_mask,
  output logic [RF_WIDTH-1:0] rf_data_out,
  output logic [4:0]          rf_count,
  output logic                rf_overrun,
  output logic                rf_error_bit,
  output logic [2:0]          rstate
);

  logic                srx_meta_r;
  logic                srx_sync_r;
  logic                srx_s;
  logic                bit_s;
  rstate_t             state_r;
  logic [3:0]          cnt_r;
  logic [2:0]          bit_cnt_r;
  logic [7:0]          shift_r;
  logic                all_zero_r;
  logic                par_err_r;
  logic                frame_err_r;
  logic                brk_r;
  logic                push_r;
  logic [RF_WIDTH-1:0] word_r;
  logic                unused_lcr_s;

  assign unused_lcr_s = ^{lcr[7:6], lcr[2]};

  // Two-flop synchroniser, idles high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srx_meta_r <= 1'b1;
      srx_sync_r <= 1'b1;
    end else begin
      srx_meta_r <= srx_pad_i;
      srx_sync_r <= srx_meta_r;
    end
  end
  assign srx_s = srx_sync_r;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] START_CNT = 4'd8;
  logic [1:0] hist_r;

  // Last two tick samples; the decision tick supplies the third vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hist_r <= 2'b11;
    else if (enable) hist_r <= {hist_r[0], srx_s};
  end
  assign bit_s = majority3(hist_r[1], hist_r[0], srx_s);
`else
  localparam logic [3:0] START_CNT = 4'd7;
  assign bit_s = srx_s;
`endif

  // Receive frame state machine; advances only on the 16x tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= r_idle;
      cnt_r       <= 4'd0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      all_zero_r  <= 1'b0;
      par_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
      brk_r       <= 1'b0;
      push_r      <= 1'b0;
      word_r      <= '0;
    end else begin
      push_r <= 1'b0;
      if (enable) begin
        case (state_r)
          r_idle: begin
            if (!srx_s) begin
              cnt_r   <= START_CNT;
              state_r <= r_rec_start;
            end
          end
          r_rec_start: begin
            if (cnt_r == 4'd0) begin
              if (bit_s) begin
                state_r <= r_idle;
              end else begin
                cnt_r      <= 4'd15;
                bit_cnt_r  <= {1'b1, lcr[LC_BITS +: 2]};
                shift_r    <= 8'd0;
                all_zero_r <= 1'b1;
                par_err_r  <= 1'b0;
                state_r    <= r_rec_bit;
              end
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
          r_rec_bit: begin
            if (cnt_r == 4'd0) begin
              shift_r    <= shift_in(shift_r, bit_s, lcr[LC_BITS +: 2]);
              all_zero_r <= all_zero_r & ~bit_s;
              cnt_r      <= 4'd15;
              if (bit_cnt_r == 3'd0) state_r <= lcr[LC_PE] ? r_rec_parity : r_rec_stop;
              else                   bit_cnt_r <= bit_cnt_r - 3'd1;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
          r_rec_parity: begin
            if (cnt_r == 4'd0) begin
              par_err_r  <= bit_s != expected_parity(shift_r, lcr[LC_EP], lcr[LC_SP]);
              all_zero_r <= all_zero_r & ~bit_s;
              cnt_r      <= 4'd15;
              state_r    <= r_rec_stop;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
          r_rec_stop: begin
            if (cnt_r == 4'd0) begin
              frame_err_r <= ~bit_s;
              brk_r       <= all_zero_r & ~bit_s;
              state_r     <= r_push;
            end else begin
              cnt_r <= cnt_r - 4'd1;
            end
          end
          r_push: begin
            push_r  <= 1'b1;
            word_r  <= brk_r ? {8'h00, 3'b101} : {shift_r, 1'b0, par_err_r, frame_err_r};
            state_r <= brk_r ? r_wait_high : r_idle;
          end
          r_wait_high: begin
            if (srx_s) state_r <= r_idle;
          end
          default: state_r <= r_idle;
        endcase
      end
    end
  end

  assign rstate = state_r;

  uart_rfifo #(.DEPTH(FIFO_DEPTH)) u_rfifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_r),
    .pop         (rf_pop),
    .flush       (rx_reset),
    .clr_overrun (lsr_mask),
    .data_in     (word_r),
    .data_out    (rf_data_out),
    .count       (rf_count),
    .overrun     (rf_overrun),
    .error_bit   (rf_error_bit)
  );

endmodule
